dmem_pipe: RTL and testbench

DMEM_PIPE -- requirements
Module: dmem_pipe

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_pipe_if.sv | 25 ++
 rtl/dmem_lane_align.sv | 67 ++++++
 rtl/dmem_pipe.sv | 110 +++++++++++
 tb/tb_dmem_pipe.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory pipe: RV32 width codes, sweep FSM states, response record.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    typedef struct packed {
        logic        vld;
        logic        we;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

endpackage

// File: rtl/dmem_pipe_if.sv
// Request/response bundle between a load-store unit (master) and the data memory (slave).
interface dmem_pipe_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_we;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_we
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_we
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational RV32 lane logic: load extract/extend, store replicate + byte mask, error decode.
// Zero latency; no flow control of its own.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int HI_W = 17
) (
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    input  logic [HI_W-1:0] addr_hi,
    input  logic [31:0]     wdata,
    input  logic [31:0]     rword,
    output logic [31:0]     rdata,
    output logic [31:0]     wword,
    output logic [3:0]      wmask,
    output logic            err
);

    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic        illegal;
    logic        misal;

    always_comb begin
        bsel    = 8'(rword >> {lane, 3'b000});
        hsel    = lane[1] ? rword[31:16] : rword[15:0];
        illegal = 1'b0;
        misal   = 1'b0;
        rdata   = '0;
        wword   = wdata;
        wmask   = 4'b0000;
        case (funct3)
            F3_B: begin
                rdata = {{24{bsel[7]}}, bsel};
                wword = {4{wdata[7:0]}};
                wmask = 4'b0001 << lane;
            end
            F3_H: begin
                misal = lane[0];
                rdata = {{16{hsel[15]}}, hsel};
                wword = {2{wdata[15:0]}};
                wmask = lane[1] ? 4'b1100 : 4'b0011;
            end
            F3_W: begin
                misal = |lane;
                rdata = rword;
                wmask = 4'b1111;
            end
            // Unsigned widths exist only for loads.
            F3_BU: begin
                illegal = we;
                rdata   = {24'b0, bsel};
            end
            F3_HU: begin
                illegal = we;
                misal   = lane[0];
                rdata   = {16'b0, hsel};
            end
            default: illegal = 1'b1;
        endcase
        err = illegal | misal | (|addr_hi);
        if (err || we) rdata = '0;
        if (err || !we) wmask = '0;
    end

endmodule

// File: rtl/dmem_pipe.sv
// Data memory, RD_LAT-cycle response pipe, no response backpressure; req_ready low only during the
// post-reset zero sweep, which exists only when DMEM_INIT_CLEAR_EN is defined.
module dmem_pipe
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 8192,
    parameter int RD_LAT      = 1
) (
    input logic        clk,
    input logic        rst_n,
    dmem_pipe_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic          ready;
    logic          accept;
    logic          clear;
    logic [AW-1:0] clr_idx;
    logic [AW-1:0] idx;
    logic [31:0]   rword;
    logic [31:0]   rdata;
    logic [31:0]   wword;
    logic [3:0]    wmask;
    logic          err;
    rsp_t          head;
    rsp_t          pipe [RD_LAT];

    assign accept = bus.req_valid && ready;
    assign idx    = bus.req_addr[AW+1:2];
    assign rword  = mem[idx];

    dmem_lane_align #(
        .HI_W (30 - AW)
    ) u_lane_align (
        .we      (bus.req_we),
        .funct3  (bus.req_funct3),
        .lane    (bus.req_addr[1:0]),
        .addr_hi (bus.req_addr[31:AW+2]),
        .wdata   (bus.req_wdata),
        .rword   (rword),
        .rdata   (rdata),
        .wword   (wword),
        .wmask   (wmask),
        .err     (err)
    );

`ifdef DMEM_INIT_CLEAR_EN
    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] init_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        clear     = 1'b0;
        case (state)
            ST_INIT: begin
                clear = 1'b1;
                if (init_cnt == AW'(DEPTH_WORDS - 1)) state_nxt = ST_READY;
            end
            ST_READY: ready = 1'b1;
        endcase
    end

    assign clr_idx = init_cnt;
`else
    assign ready   = 1'b1;
    assign clear   = 1'b0;
    assign clr_idx = '0;
`endif

    // The array has no reset: committed stores survive rst_n.
    always_ff @(posedge clk) begin
        if (clear) mem[clr_idx] <= '0;
        for (int i = 0; i < 4; i++) begin
            if (accept && wmask[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
        end
    end

    // Idle slots carry all-zero records so the outputs read 0 between responses.
    assign head = accept ? '{vld: 1'b1, we: bus.req_we, err: err, rdata: rdata} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= head;
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = pipe[RD_LAT-1].vld;
    assign bus.rsp_we    = pipe[RD_LAT-1].we;
    assign bus.rsp_err   = pipe[RD_LAT-1].err;
    assign bus.rsp_rdata = pipe[RD_LAT-1].rdata;

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench for dmem_pipe: two instances (RD_LAT 1 and 3, 256 words) share one request stream;
// expected responses are queued per instance with their due cycle.
module tb_dmem_pipe;
    import dmem_pkg::*;

    localparam int DEPTH = 256;
    localparam int LAT0  = 1;
    localparam int LAT1  = 3;
`ifdef DMEM_INIT_CLEAR_EN
    localparam int EXP_INIT_CYC = DEPTH;
    localparam logic EXP_RST_RDY = 1'b0;
`else
    localparam int EXP_INIT_CYC = 0;
    localparam logic EXP_RST_RDY = 1'b1;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        we;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    exp_t        q [2][$];
    rsp_t        obs [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_pipe_if ia ();
    dmem_pipe_if ib ();

    assign ia.req_valid = req_valid;   assign ib.req_valid = req_valid;
    assign ia.req_we = req_we;         assign ib.req_we = req_we;
    assign ia.req_funct3 = req_funct3; assign ib.req_funct3 = req_funct3;
    assign ia.req_addr = req_addr;     assign ib.req_addr = req_addr;
    assign ia.req_wdata = req_wdata;   assign ib.req_wdata = req_wdata;

    assign obs[0] = {ia.rsp_valid, ia.rsp_we, ia.rsp_err, ia.rsp_rdata};
    assign obs[1] = {ib.rsp_valid, ib.rsp_we, ib.rsp_err, ib.rsp_rdata};

    dmem_pipe #(.DEPTH_WORDS(DEPTH), .RD_LAT(LAT0)) u_dut_lat1 (.clk(clk), .rst_n(rst_n), .bus(ia));
    dmem_pipe #(.DEPTH_WORDS(DEPTH), .RD_LAT(LAT1)) u_dut_lat3 (.clk(clk), .rst_n(rst_n), .bus(ib));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Every cycle out of reset: rsp_valid must match exactly the queued due cycles.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int d = 0; d < 2; d++) begin
                    logic ev;
                    exp_t e;
                    ev = (q[d].size() > 0) && (q[d][0].due == cyc);
                    check($sformatf("rsp_valid[%0d]@%0d", d, cyc), 32'(obs[d].vld), 32'(ev));
                    if (ev) begin
                        e = q[d].pop_front();
                        check($sformatf("rsp_rdata[%0d]@%0d", d, cyc), obs[d].rdata, e.rdata);
                        check($sformatf("rsp_err[%0d]@%0d", d, cyc), 32'(obs[d].err), 32'(e.err));
                        check($sformatf("rsp_we[%0d]@%0d", d, cyc), 32'(obs[d].we), 32'(e.we));
                    end
                end
            end
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
        int waited;
        waited = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (!(ia.req_ready && ib.req_ready) && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 1000) check("req_ready_timeout", 32'(waited), 32'd0);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        q[0].push_back('{exp_rdata, exp_err, we, cyc + LAT0});
        q[1].push_back('{exp_rdata, exp_err, we, cyc + LAT1});
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic count_init(input string tag);
        int lowc;
        lowc = 0;
        while (lowc < 1000) begin
            @(negedge clk);
            if (ia.req_ready) break;
            lowc++;
        end
        check(tag, 32'(lowc), 32'(EXP_INIT_CYC));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
        fork monitor(); join_none
        #1 rst_n = 1'b0;
        #2;
        check("rst_rsp_valid_lat1", 32'(ia.rsp_valid), 32'd0);
        check("rst_rsp_valid_lat3", 32'(ib.rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(ib.rsp_err), 32'd0);
        check("rst_rsp_we", 32'(ib.rsp_we), 32'd0);
        check("rst_rsp_rdata", ib.rsp_rdata, 32'd0);
        check("rst_req_ready", 32'(ia.req_ready), 32'(EXP_RST_RDY));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        count_init("init_ready_low_cycles");

        // Extraction and extension from one word
        issue(1, F3_W,  32'h10, 32'h8000_00F0, 32'h0, 0);
        issue(0, F3_B,  32'h10, 32'h0, 32'hFFFF_FFF0, 0);
        issue(0, F3_BU, 32'h13, 32'h0, 32'h0000_0080, 0);
        issue(0, F3_HU, 32'h12, 32'h0, 32'h0000_8000, 0);
        issue(0, F3_H,  32'h10, 32'h0, 32'h0000_00F0, 0);
        // Store merge, then load on the very next cycle
        issue(1, F3_W,  32'h20, 32'h1122_3344, 32'h0, 0);
        issue(1, F3_B,  32'h21, 32'h0000_00AA, 32'h0, 0);
        issue(0, F3_W,  32'h20, 32'h0, 32'h1122_AA44, 0);
        // Misaligned accesses
        issue(0, F3_H,  32'h21, 32'h0, 32'h0, 1);
        issue(1, F3_W,  32'h22, 32'hFFFF_FFFF, 32'h0, 1);
        issue(0, F3_W,  32'h20, 32'h0, 32'h1122_AA44, 0);
        // Range: no wrap onto word 0
        issue(1, F3_W,  32'h00, 32'h5566_7788, 32'h0, 0);
        issue(1, F3_W,  32'h400, 32'hDEAD_BEEF, 32'h0, 1);
        issue(0, F3_W,  32'h00, 32'h0, 32'h5566_7788, 0);
        issue(0, F3_W,  32'h8000_0000, 32'h0, 32'h0, 1);
        issue(1, F3_B,  32'h3FF, 32'h0000_0080, 32'h0, 0);
        issue(0, F3_B,  32'h3FF, 32'h0, 32'hFFFF_FF80, 0);
        // Illegal width codes
        issue(0, 3'b011, 32'h00, 32'h0, 32'h0, 1);
        issue(1, F3_BU,  32'h00, 32'hFFFF_FFFF, 32'h0, 1);
        issue(1, F3_HU,  32'h00, 32'hFFFF_FFFF, 32'h0, 1);
        issue(0, 3'b110, 32'h00, 32'h0, 32'h0, 1);
        issue(0, 3'b111, 32'h00, 32'h0, 32'h0, 1);
        issue(0, F3_W,   32'h00, 32'h0, 32'h5566_7788, 0);
        // Halfword lanes
        issue(1, F3_W,  32'h28, 32'h0102_0304, 32'h0, 0);
        issue(1, F3_H,  32'h2A, 32'h1234_BEEF, 32'h0, 0);
        issue(0, F3_W,  32'h28, 32'h0, 32'hBEEF_0304, 0);
        issue(0, F3_H,  32'h2A, 32'h0, 32'hFFFF_BEEF, 0);
        issue(0, F3_B,  32'h2B, 32'h0, 32'hFFFF_FFBE, 0);
        issue(0, F3_BU, 32'h29, 32'h0, 32'h0000_0003, 0);
        issue(1, F3_H,  32'h28, 32'h0000_7FFF, 32'h0, 0);
        issue(0, F3_H,  32'h28, 32'h0, 32'h0000_7FFF, 0);
        issue(0, F3_HU, 32'h2A, 32'h0, 32'h0000_BEEF, 0);
        // Back-to-back loads, spaced from earlier traffic
        issue(1, F3_W,  32'h04, 32'h0000_000A, 32'h0, 0);
        issue(1, F3_W,  32'h08, 32'h0000_000B, 32'h0, 0);
        idle(5);
        issue(0, F3_W,  32'h00, 32'h0, 32'h5566_7788, 0);
        issue(0, F3_W,  32'h04, 32'h0, 32'h0000_000A, 0);
        issue(0, F3_W,  32'h08, 32'h0, 32'h0000_000B, 0);
        idle(6);
        check("drain_q_lat1", 32'(q[0].size()), 32'd0);
        check("drain_q_lat3", 32'(q[1].size()), 32'd0);

        // Reset while the RD_LAT=3 pipe holds three loads and its first response is on the bus
        issue(0, F3_W,  32'h00, 32'h0, 32'h5566_7788, 0);
        issue(0, F3_W,  32'h04, 32'h0, 32'h0000_000A, 0);
        issue(0, F3_W,  32'h08, 32'h0, 32'h0000_000B, 0);
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q[0].delete();
        q[1].delete();
        check("midrst_valid_lat1", 32'(ia.rsp_valid), 32'd0);
        check("midrst_valid_lat3", 32'(ib.rsp_valid), 32'd0);
        check("midrst_rdata_lat3", ib.rsp_rdata, 32'd0);
        repeat (3) @(posedge clk);
        check("midrst_valid_hold", 32'(ib.rsp_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        count_init("init_ready_low_cycles_2");
`ifdef DMEM_INIT_CLEAR_EN
        issue(0, F3_W, 32'h20,  32'h0, 32'h0, 0);
        issue(0, F3_W, 32'h3FC, 32'h0, 32'h0, 0);
`else
        issue(0, F3_W, 32'h20,  32'h0, 32'h1122_AA44, 0);
        issue(0, F3_W, 32'h3FC, 32'h0, 32'h8000_0000, 0);
`endif
        idle(6);
        check("final_q_lat1", 32'(q[0].size()), 32'd0);
        check("final_q_lat3", 32'(q[1].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
